signal_monitor_exerciser: RTL and testbench

Self-checking stimulus source for the signal monitor. The exerciser drives the monitor's `signal_a`, `signal_b` and `mode_select` inputs from an LFSR vector sequence. It samples the monitor's `status_leds` and registered `control_out`, and compares both against an internal golden model. It sits at the monitor's input/output boundary on the board-level test harness. It reports pass/fail, an error count and the first failing vector index.

---
 rtl/signal_monitor_exerciser.sv | 171 +++++++++++++++++
 tb/tb_signal_monitor_exerciser.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_monitor_exerciser.sv
// Stimulus source and checker for the signal monitor: drives LFSR-derived vectors, compares the
// monitor's status/control against a golden model and reports pass, error count and first failure.
module signal_monitor_exerciser #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mon_control,
    input  logic [2:0] mon_status,
    output logic [3:0] drv_a,
    output logic [3:0] drv_b,
    output logic [1:0] drv_mode,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_fail
);

    localparam logic [7:0] SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LastIdx = 8'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StCheck, StRamp, StDone} state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] idx;
    logic [2:0] r;
    logic [2:0] status_cap;
    logic       ramp_err;

    logic [7:0] lfsr_next;
    logic [3:0] sum;
    logic [3:0] exp_control;
    logic [2:0] exp_status;
    logic [3:0] ramp_exp;
    logic       check_miss;
    logic       ramp_miss;
    logic       vec_end;
    logic       vec_err;
    logic [7:0] err_inc;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign sum       = drv_a + drv_b;

    // Golden model, evaluated on the held drive values of the current vector
    always_comb begin
        exp_control = 4'h0;
        exp_status  = 3'b111;
        case (drv_mode)
            2'b00: begin
                exp_control = sum;
                exp_status  = 3'b001;
            end
            2'b01: begin
                if (drv_a > drv_b) begin
                    exp_control = drv_a - drv_b;
                    exp_status  = 3'b100;
                end else if (drv_a < drv_b) begin
                    exp_control = drv_b - drv_a;
                    exp_status  = 3'b010;
                end else begin
                    exp_control = 4'h0;
                    exp_status  = 3'b001;
                end
            end
            2'b11: begin
                exp_control = sum >> 1;
                exp_status  = 3'b111;
            end
            default: begin
                exp_control = 4'h0;
                exp_status  = 3'b111;
            end
        endcase
    end

    // Control value expected at the end of ramp cycle r (r >= 1)
    always_comb begin
        case (r)
            3'd1:    ramp_exp = 4'd0;
            3'd2:    ramp_exp = 4'd5;
            3'd3:    ramp_exp = 4'd10;
            default: ramp_exp = 4'd15;
        endcase
    end

    assign check_miss = (status_cap != exp_status) || (mon_control != exp_control);
    assign ramp_miss  = (mon_status != 3'b111) || ((r != 3'd0) && (mon_control != ramp_exp));
    assign vec_end    = (state == StCheck) || ((state == StRamp) && (r == 3'd4));
    assign vec_err    = (state == StCheck) ? check_miss : (ramp_err | ramp_miss);
    assign err_inc    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            lfsr       <= SeedEff;
            idx        <= 8'd0;
            r          <= 3'd0;
            status_cap <= 3'd0;
            ramp_err   <= 1'b0;
            drv_a      <= 4'h0;
            drv_b      <= 4'h0;
            drv_mode   <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            first_fail <= 8'hFF;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StLoad;
                        lfsr       <= SeedEff;
                        idx        <= 8'd0;
                        err_count  <= 8'd0;
                        first_fail <= 8'hFF;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                StLoad: begin
                    drv_a    <= lfsr[7:4];
                    drv_b    <= lfsr[3:0];
                    drv_mode <= idx[1:0];
                    if (idx[1:0] == 2'b10) begin
                        state    <= StRamp;
                        r        <= 3'd0;
                        ramp_err <= 1'b0;
                    end else begin
                        state <= StSettle;
                    end
                end
                StSettle: begin
                    status_cap <= mon_status;
                    state      <= StCheck;
                end
                StCheck: begin
                end
                StRamp: begin
                    ramp_err <= ramp_err | ramp_miss;
                    if (r != 3'd4) r <= r + 3'd1;
                end
                default: state <= StIdle;
            endcase

            // One error at most per vector, committed on its final edge
            if (vec_end) begin
                if (vec_err) begin
                    err_count <= err_inc;
                    if (first_fail == 8'hFF) first_fail <= idx;
                end
                lfsr <= lfsr_next;
                idx  <= idx + 8'd1;
                if (idx == LastIdx) begin
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == 8'd0) && !vec_err;
                end else begin
                    state <= StLoad;
                end
            end
        end
    end

endmodule

// File: tb/tb_signal_monitor_exerciser.sv
// Bench for signal_monitor_exerciser: three instances (golden config, SEED=0 x255, single vector)
// each wired to a behavioural monitor with selectable faults.
module tb_signal_monitor_exerciser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start      [3];
    logic [3:0] drv_a      [3];
    logic [3:0] drv_b      [3];
    logic [1:0] drv_mode   [3];
    logic       busy       [3];
    logic       done       [3];
    logic       pass       [3];
    logic [7:0] err_count  [3];
    logic [7:0] first_fail [3];

    // 0 none, 1 mode-11 un-halved, 2 ramp last step 14, 3 status stuck at 000
    int fault = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] mode;
    } vec_t;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_inst
        logic [3:0] mon_ctl;
        logic [3:0] sum;
        logic [2:0] mon_st;
        logic [2:0] cnt;

        assign sum = drv_a[g] + drv_b[g];

        always_comb begin
            mon_st = 3'b111;
            if (fault == 3) mon_st = 3'b000;
            else if (drv_mode[g] == 2'b00) mon_st = 3'b001;
            else if (drv_mode[g] == 2'b01)
                mon_st = (drv_a[g] > drv_b[g]) ? 3'b100 :
                         (drv_a[g] < drv_b[g]) ? 3'b010 : 3'b001;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mon_ctl <= 4'h0;
                cnt     <= 3'd0;
            end else begin
                case (drv_mode[g])
                    2'b00: begin
                        mon_ctl <= sum;
                        cnt     <= 3'd0;
                    end
                    2'b01: begin
                        mon_ctl <= (drv_a[g] > drv_b[g]) ? drv_a[g] - drv_b[g]
                                                         : drv_b[g] - drv_a[g];
                        cnt     <= 3'd0;
                    end
                    2'b11: begin
                        mon_ctl <= (fault == 1) ? sum : (sum >> 1);
                        cnt     <= 3'd0;
                    end
                    default: begin
                        case (cnt)
                            3'd0:    mon_ctl <= 4'd0;
                            3'd1:    mon_ctl <= 4'd5;
                            3'd2:    mon_ctl <= 4'd10;
                            default: mon_ctl <= (fault == 2) ? 4'd14 : 4'd15;
                        endcase
                        cnt <= cnt + 3'd1;
                    end
                endcase
            end
        end

        signal_monitor_exerciser #(
            .NUM_VECTORS(g == 0 ? 4 : (g == 1 ? 255 : 1)),
            .SEED       (g == 1 ? 8'h00 : 8'hA5)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .mon_control(mon_ctl),
            .mon_status (mon_st),
            .drv_a      (drv_a[g]),
            .drv_b      (drv_b[g]),
            .drv_mode   (drv_mode[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .err_count  (err_count[g]),
            .first_fail (first_fail[g])
        );
    end

    // Pushes the expected vectors, pulses start, then pops and compares one vector per LOAD exit.
    task automatic run_vectors(input int g, input int nv, input logic [7:0] seed, input bit poke);
        logic [7:0] l;
        vec_t       e;
        int         len;
        bit         early;
        l = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < nv; k++) begin
            e.a    = l[7:4];
            e.b    = l[3:0];
            e.mode = 2'(k % 4);
            exp_q.push_back(e);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        early = 1'b0;
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        for (int k = 0; k < nv; k++) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            n_checks++;
            if ({drv_a[g], drv_b[g], drv_mode[g]} !== e) begin
                $display("FAIL drive[%0d] inst%0d: got %h/%h/%b expected %h/%h/%b", k, g,
                         drv_a[g], drv_b[g], drv_mode[g], e.a, e.b, e.mode);
            end else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (busy[g] !== 1'b1) $display("FAIL busy_in_run: got %b expected 1", busy[g]);
                else n_pass++;
            end
            early |= (done[g] === 1'b1);
            len = (e.mode == 2'b10) ? 6 : 3;
            for (int c = 1; c < len; c++) begin
                @(posedge clk);
                #1;
                start[g] = poke && (k == 1) && (c == 1);
                if (!((k == nv - 1) && (c == len - 1))) early |= (done[g] === 1'b1);
            end
        end
        start[g] = 1'b0;
        n_checks++;
        if (early !== 1'b0) $display("FAIL done_early inst%0d: got 1 expected 0", g);
        else n_pass++;
        n_checks++;
        if ({done[g], busy[g]} !== 2'b10)
            $display("FAIL done_timing inst%0d: got done=%b busy=%b expected 1/0", g, done[g], busy[g]);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({drv_a[g], drv_b[g], drv_mode[g], busy[g], done[g], pass[g], err_count[g],
                 first_fail[g]} !== {10'h0, 3'b000, 8'h00, 8'hFF})
                $display("FAIL reset_values inst%0d: got drv=%h%h%b b/d/p=%b%b%b err=%h ff=%h expected 0s ff=FF",
                         g, drv_a[g], drv_b[g], drv_mode[g], busy[g], done[g], pass[g],
                         err_count[g], first_fail[g]);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_golden;
        fault = 0;
        run_vectors(0, 4, 8'hA5, 1'b0);
        n_checks++;
        if ({pass[0], err_count[0], first_fail[0]} !== {1'b1, 8'd0, 8'hFF})
            $display("FAIL golden_results: got pass=%b err=%0d ff=%h expected 1/0/ff",
                     pass[0], err_count[0], first_fail[0]);
        else n_pass++;
    endtask

    task automatic test_mode11_fault;
        fault = 1;
        run_vectors(0, 4, 8'hA5, 1'b0);
        n_checks++;
        if ({pass[0], err_count[0], first_fail[0]} !== {1'b0, 8'd1, 8'd3})
            $display("FAIL mode11_fault: got pass=%b err=%0d ff=%h expected 0/1/03",
                     pass[0], err_count[0], first_fail[0]);
        else n_pass++;
        fault = 0;
    endtask

    task automatic test_ramp_fault;
        fault = 2;
        run_vectors(0, 4, 8'hA5, 1'b0);
        n_checks++;
        if ({pass[0], err_count[0], first_fail[0]} !== {1'b0, 8'd1, 8'd2})
            $display("FAIL ramp_fault: got pass=%b err=%0d ff=%h expected 0/1/02",
                     pass[0], err_count[0], first_fail[0]);
        else n_pass++;
        fault = 0;
    endtask

    task automatic test_reset_mid_ramp;
        fault = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        // Edges T+1..T+9 put vector 2 in ramp cycle r=2
        repeat (9) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (drv_mode[0] !== 2'b10) $display("FAIL mid_ramp_setup: got mode %b expected 10", drv_mode[0]);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy[0], done[0], pass[0], drv_a[0], drv_b[0], drv_mode[0], err_count[0],
             first_fail[0]} !== {3'b000, 10'h0, 8'h00, 8'hFF})
            $display("FAIL reset_mid_ramp: got b/d/p=%b%b%b drv=%h%h%b err=%h ff=%h expected 0s ff=FF",
                     busy[0], done[0], pass[0], drv_a[0], drv_b[0], drv_mode[0], err_count[0],
                     first_fail[0]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        test_golden();
    endtask

    task automatic test_start_while_busy;
        fault = 0;
        run_vectors(0, 4, 8'hA5, 1'b1);
        n_checks++;
        if ({pass[0], err_count[0], first_fail[0]} !== {1'b1, 8'd0, 8'hFF})
            $display("FAIL start_busy_results: got pass=%b err=%0d ff=%h expected 1/0/ff",
                     pass[0], err_count[0], first_fail[0]);
        else n_pass++;
    endtask

    task automatic test_single_vector;
        fault = 0;
        run_vectors(2, 1, 8'hA5, 1'b0);
        n_checks++;
        if ({pass[2], err_count[2], first_fail[2]} !== {1'b1, 8'd0, 8'hFF})
            $display("FAIL single_vector: got pass=%b err=%0d ff=%h expected 1/0/ff",
                     pass[2], err_count[2], first_fail[2]);
        else n_pass++;
    endtask

    task automatic test_seed0_saturation;
        fault = 3;
        run_vectors(1, 255, 8'h00, 1'b0);
        n_checks++;
        if ({pass[1], err_count[1], first_fail[1]} !== {1'b0, 8'd255, 8'd0})
            $display("FAIL saturation: got pass=%b err=%0d ff=%h expected 0/255/00",
                     pass[1], err_count[1], first_fail[1]);
        else n_pass++;
        fault = 0;
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mode11_fault();
        test_ramp_fault();
        test_reset_mid_ramp();
        test_start_while_busy();
        test_single_vector();
        test_seed0_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
